// File: rtl/cpu_boot_loader.sv
// Byte-stream boot loader: assembles big-endian words into imem,
// verifies an XOR checksum, then releases the CPU from reset.
module cpu_boot_loader #(
  parameter int ADDR_W    = 8,
  parameter int WORD_W    = 16,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              boot_done,
  output logic              boot_err
);

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [15:0] LP_MAX = 16'(MAX_WORDS);

  state_t              r_state;
  state_t              w_next;
  logic [15:0]         r_cnt;
  logic [15:0]         r_words;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_chk;
  logic [7:0]          r_hi;
  logic                r_ready;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [WORD_W-1:0]   r_wdata;
  logic                r_cpu_rst;
  logic                r_done;
  logic                r_err;
  logic                w_acc;
  logic [15:0]         w_count;
  logic                w_last;

  assign w_acc   = byte_valid & r_ready;
  assign w_count = {r_cnt[15:8], byte_in};
  assign w_last  = (r_words + 16'd1) == r_cnt;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_HDR_HI;
    else      r_state <= w_next;
  end

  // Next-state decode; only an accepted byte moves the FSM
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_HDR_HI: if (w_acc) w_next = S_HDR_LO;
      S_HDR_LO: begin
        if (w_acc) begin
          if (w_count > LP_MAX)      w_next = S_ERR;
          else if (w_count == 16'd0) w_next = S_CHK;
          else                       w_next = S_DAT_HI;
        end
      end
      S_DAT_HI: if (w_acc) w_next = S_DAT_LO;
      S_DAT_LO: begin
        if (w_acc) w_next = w_last ? S_CHK : S_DAT_HI;
      end
      S_CHK: begin
        if (w_acc) w_next = (byte_in == r_chk) ? S_DONE : S_ERR;
      end
      S_DONE:  w_next = S_DONE;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_ERR;
    endcase
  end

  // Datapath: header/count latch, checksum, word assembly, imem write
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_words   <= '0;
      r_addr    <= '0;
      r_chk     <= '0;
      r_hi      <= '0;
      r_ready   <= 1'b0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_ready   <= (w_next != S_DONE) && (w_next != S_ERR);
      r_we      <= 1'b0;
      r_cpu_rst <= (w_next != S_DONE);
      r_done    <= (w_next == S_DONE);
      r_err     <= (w_next == S_ERR);
      if (w_acc) begin
        unique case (r_state)
          S_HDR_HI: r_cnt[15:8] <= byte_in;
          S_HDR_LO: r_cnt[7:0]  <= byte_in;
          S_DAT_HI: begin
            r_hi  <= byte_in;
            r_chk <= r_chk ^ byte_in;
          end
          S_DAT_LO: begin
            r_chk   <= r_chk ^ byte_in;
            r_we    <= 1'b1;
            r_wdata <= WORD_W'({r_hi, byte_in});
            r_waddr <= r_addr;
            r_addr  <= r_addr + 1'b1;
            r_words <= r_words + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign byte_ready = r_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_waddr;
  assign imem_wdata = r_wdata;
  assign cpu_rst    = r_cpu_rst;
  assign boot_done  = r_done;
  assign boot_err   = r_err;

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Directed bench for cpu_boot_loader: frames, checksum errors,
// oversize headers, stalls, mid-load reset and post-boot lockout.
module tb_cpu_boot_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_rst;
  logic        boot_done;
  logic        boot_err;

  int total = 0;
  int bad   = 0;
  logic [23:0] wq[$];

  cpu_boot_loader dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .boot_done  (boot_done),
    .boot_err   (boot_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Record every write strobe as {addr, data}
  always @(negedge clk) begin
    if (imem_we) wq.push_back({imem_addr, imem_wdata});
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 0;
    byte_valid = 1;
    byte_in    = 8'hAA;
    @(negedge clk);
    @(negedge clk);
    check("rst_rdy",  32'(byte_ready), 0);
    check("rst_we",   32'(imem_we),    0);
    check("rst_addr", 32'(imem_addr),  0);
    check("rst_wd",   32'(imem_wdata), 0);
    check("rst_cpu",  32'(cpu_rst),    1);
    check("rst_done", 32'(boot_done),  0);
    check("rst_err",  32'(boot_err),   0);
    byte_valid = 0;
    rst        = 1;
    wq.delete();
  endtask

  // Offer one byte from a negedge; returns after the accepting posedge
  task automatic send(input logic [7:0] b, input bit gap);
    int n;
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      check("accept_tmo", 0, 1);
    end else begin
      @(posedge clk);
    end
    if (gap) begin
      @(negedge clk);
      byte_valid = 0;
    end
  endtask

  task automatic send_frame(input logic [7:0] f[], input bit gap);
    foreach (f[i]) send(f[i], gap);
    @(negedge clk);
    byte_valid = 0;
    @(negedge clk);
  endtask

  task automatic hold_valid(input int cyc);
    @(negedge clk);
    byte_in    = 8'h77;
    byte_valid = 1;
    repeat (cyc) @(negedge clk);
    byte_valid = 0;
  endtask

  initial begin
    logic [7:0] f[];
    rst        = 1;
    byte_valid = 0;
    byte_in    = 0;

    // 1: good two-word frame
    do_reset();
    f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_frame(f, 0);
    check("t1_nw",   32'(wq.size()), 2);
    check("t1_w0",   32'(wq[0]), 32'h00_1234);
    check("t1_w1",   32'(wq[1]), 32'h01_ABCD);
    check("t1_done", 32'(boot_done), 1);
    check("t1_cpu",  32'(cpu_rst),   0);
    check("t1_err",  32'(boot_err),  0);
    check("t1_rdy",  32'(byte_ready), 0);

    // 2: bad checksum
    do_reset();
    f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    send_frame(f, 0);
    hold_valid(5);
    check("t2_err",  32'(boot_err),   1);
    check("t2_cpu",  32'(cpu_rst),    1);
    check("t2_rdy",  32'(byte_ready), 0);
    check("t2_done", 32'(boot_done),  0);
    check("t2_nw",   32'(wq.size()),  2);

    // 3a: empty image
    do_reset();
    f = '{8'h00, 8'h00, 8'h00};
    send_frame(f, 0);
    check("t3_nw",   32'(wq.size()), 0);
    check("t3_done", 32'(boot_done), 1);
    check("t3_cpu",  32'(cpu_rst),   0);

    // 3b: oversize header
    do_reset();
    f = '{8'h01, 8'h01};
    send_frame(f, 0);
    check("t3_big_err", 32'(boot_err),   1);
    check("t3_big_rdy", 32'(byte_ready), 0);
    check("t3_big_cpu", 32'(cpu_rst),    1);

    // 4: one word with valid toggling
    do_reset();
    f = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51};
    send_frame(f, 1);
    check("t4_nw",   32'(wq.size()), 1);
    check("t4_w0",   32'(wq[0]), 32'h00_BEEF);
    check("t4_done", 32'(boot_done), 1);
    check("t4_cpu",  32'(cpu_rst),   0);

    // 5: reset mid-load, then full frame
    do_reset();
    f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    send_frame(f, 0);
    check("t5_part", 32'(wq.size()), 1);
    do_reset();
    f = '{8'h00, 8'h02, 8'h5A, 8'hA5, 8'h0F, 8'hF0, 8'h00};
    send_frame(f, 0);
    check("t5_nw",   32'(wq.size()), 2);
    check("t5_w0",   32'(wq[0]), 32'h00_5AA5);
    check("t5_w1",   32'(wq[1]), 32'h01_0FF0);
    check("t5_done", 32'(boot_done), 1);

    // 6: bytes after DONE are ignored
    hold_valid(6);
    check("t6_rdy",  32'(byte_ready), 0);
    check("t6_nw",   32'(wq.size()),  2);
    check("t6_done", 32'(boot_done),  1);
    check("t6_cpu",  32'(cpu_rst),    0);
    check("t6_err",  32'(boot_err),   0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
